fpaddsub_issue_arbiter: RTL and testbench

- Shares one fixed-latency FPAddSub pipeline (adder plus its exception stage) between two requesters.
- Arbitrates issue round-robin and carries a requester tag down a shift pipe matched to the adder latency.
- Steers each result and its 5-bit exception flags back to the requester that issued it.
- Keeps an accumulated (sticky) IEEE flag register per requester, cleared only on request.

---
 rtl/fpaddsub_issue_arbiter.sv | 159 +++++++++++++++
 tb/tb_fpaddsub_issue_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpaddsub_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fpaddsub_issue_arbiter
// Desc   : Round-robin issue of two requesters onto one fixed-latency FPAddSub
//          pipe; a tag pipe steers results/flags back; per-requester sticky
//          flags. Optional trap/irq logic under macro FPADDSUB_ARB_TRAP_EN.
// Rev    : 1.0  initial release
// ============================================================================
module fpaddsub_issue_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_op,
    output logic        au_valid,
    output logic [31:0] au_a,
    output logic [31:0] au_b,
    output logic        au_op,
    input  logic [31:0] au_p,
    input  logic [4:0]  au_flags,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_p,
    output logic [4:0]  rsp0_flags,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_p,
    output logic [4:0]  rsp1_flags,
    output logic [4:0]  sticky0,
    output logic [4:0]  sticky1,
    input  logic        clr0,
    input  logic        clr1
`ifdef FPADDSUB_ARB_TRAP_EN
    ,
    input  logic [4:0]  trap_mask0,
    input  logic [4:0]  trap_mask1,
    output logic        irq0,
    output logic        irq1
`endif
);

    logic               elig0, elig1;
    logic               grant0, grant1;
    logic               ptr;
    logic               au_tag;
    logic [LATENCY-1:0] tag_v;
    logic [LATENCY-1:0] tag_id;
    logic               fin0, fin1;

`ifdef FPADDSUB_ARB_TRAP_EN
    assign elig0 = req0_valid & ~irq0;
    assign elig1 = req1_valid & ~irq1;
`else
    assign elig0 = req0_valid;
    assign elig1 = req1_valid;
`endif

    // Pointer only breaks ties; a lone eligible requester always wins.
    always_comb begin
        grant0 = elig0 & (~elig1 | ~ptr);
        grant1 = elig1 & (~elig0 | ptr);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            au_valid <= 1'b0;
            au_a     <= '0;
            au_b     <= '0;
            au_op    <= 1'b0;
            au_tag   <= 1'b0;
            ptr      <= 1'b0;
        end else begin
            au_valid <= grant0 | grant1;
            if (grant0) begin
                au_a   <= req0_a;
                au_b   <= req0_b;
                au_op  <= req0_op;
                au_tag <= 1'b0;
                ptr    <= 1'b1;
            end else if (grant1) begin
                au_a   <= req1_a;
                au_b   <= req1_b;
                au_op  <= req1_op;
                au_tag <= 1'b1;
                ptr    <= 1'b0;
            end
        end
    end

    // au_valid/au_tag is the issue stage; LATENCY more stages put the last
    // one in the same cycle as the matching au_p/au_flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= au_valid;
            tag_id[0] <= au_tag;
            for (int i = LATENCY - 1; i > 0; i--) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign fin0 = tag_v[LATENCY-1] & ~tag_id[LATENCY-1];
    assign fin1 = tag_v[LATENCY-1] &  tag_id[LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_p     <= '0;
            rsp0_flags <= '0;
            rsp1_valid <= 1'b0;
            rsp1_p     <= '0;
            rsp1_flags <= '0;
            sticky0    <= '0;
            sticky1    <= '0;
        end else begin
            rsp0_valid <= fin0;
            rsp1_valid <= fin1;
            if (fin0) begin
                rsp0_p     <= au_p;
                rsp0_flags <= au_flags;
            end
            if (fin1) begin
                rsp1_p     <= au_p;
                rsp1_flags <= au_flags;
            end
            // A clear coinciding with a new response keeps the new flags.
            sticky0 <= (clr0 ? 5'd0 : sticky0) | (fin0 ? au_flags : 5'd0);
            sticky1 <= (clr1 ? 5'd0 : sticky1) | (fin1 ? au_flags : 5'd0);
        end
    end

`ifdef FPADDSUB_ARB_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq0 <= 1'b0;
            irq1 <= 1'b0;
        end else begin
            irq0 <= (irq0 & ~clr0) | (fin0 & (|(au_flags & trap_mask0)));
            irq1 <= (irq1 & ~clr1) | (fin1 & (|(au_flags & trap_mask1)));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpaddsub_issue_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized + directed bench for fpaddsub_issue_arbiter against a
// transaction-level model (expected-response queue keyed by due cycle).
module tb_fpaddsub_issue_arbiter;
    localparam int LAT = 4;
`ifdef FPADDSUB_ARB_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 0, req1_valid = 0, req0_op = 0, req1_op = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        req0_ready, req1_ready;
    logic        au_valid, au_op;
    logic [31:0] au_a, au_b, au_p;
    logic [4:0]  au_flags;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_p, rsp1_p;
    logic [4:0]  rsp0_flags, rsp1_flags, sticky0, sticky1;
    logic        clr0 = 0, clr1 = 0;
    logic [4:0]  trap_mask0 = 5'b10000, trap_mask1 = 5'b00100;
    logic        irq0, irq1;

    always #5 clk = ~clk;

    fpaddsub_issue_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op),
        .au_valid(au_valid), .au_a(au_a), .au_b(au_b), .au_op(au_op),
        .au_p(au_p), .au_flags(au_flags),
        .rsp0_valid(rsp0_valid), .rsp0_p(rsp0_p), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_p(rsp1_p), .rsp1_flags(rsp1_flags),
        .sticky0(sticky0), .sticky1(sticky1), .clr0(clr0), .clr1(clr1)
`ifdef FPADDSUB_ARB_TRAP_EN
        , .trap_mask0(trap_mask0), .trap_mask1(trap_mask1), .irq0(irq0), .irq1(irq1)
`endif
    );
`ifndef FPADDSUB_ARB_TRAP_EN
    assign irq0 = 1'b0;
    assign irq1 = 1'b0;
`endif

    // Stand-in adder: fixed latency, flags taken from operand B's low bits.
    function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b,
                                             input logic op);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op) return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + {31'd0, op};
    endfunction

    logic [31:0] ad_p [LAT];
    logic [4:0]  ad_f [LAT];
    always @(posedge clk) begin
        ad_p[0] <= fake_add(au_a, au_b, au_op);
        ad_f[0] <= au_b[4:0];
        for (int i = 1; i < LAT; i++) begin
            ad_p[i] <= ad_p[i-1];
            ad_f[i] <= ad_f[i-1];
        end
    end
    assign au_p     = ad_p[LAT-1];
    assign au_flags = ad_f[LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] p;
        logic [4:0]  f;
    } exp_t;
    exp_t        q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          m_ptr;
    bit          m_au_valid;
    bit   [1:0]  m_rv, m_irq;
    logic [31:0] m_rp [2];
    logic [4:0]  m_rf [2];
    logic [4:0]  m_st [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_grant(output bit g0, output bit g1);
        bit e0, e1;
        e0 = req0_valid && !m_irq[0];
        e1 = req1_valid && !m_irq[1];
        g0 = 0;
        g1 = 0;
        if (e0 && e1) begin
            if (m_ptr) g1 = 1; else g0 = 1;
        end else begin
            g0 = e0;
            g1 = e1;
        end
    endfunction

    task automatic model_reset();
        q.delete();
        m_ptr = 0; m_au_valid = 0; m_rv = 0; m_irq = 0;
        for (int n = 0; n < 2; n++) begin
            m_rp[n] = 0; m_rf[n] = 0; m_st[n] = 0;
        end
    endtask

    task automatic model_edge();
        bit g0, g1, c;
        logic [4:0] mask;
        exp_t e;
        model_grant(g0, g1);
        m_rv = 0;
        if (q.size() > 0 && q[0].due == cyc + 1) begin
            e = q.pop_front();
            m_rv[e.id] = 1;
            m_rp[e.id] = e.p;
            m_rf[e.id] = e.f;
        end
        for (int n = 0; n < 2; n++) begin
            c    = (n == 0) ? clr0 : clr1;
            mask = (n == 0) ? trap_mask0 : trap_mask1;
            m_st[n]  = (c ? 5'd0 : m_st[n]) | (m_rv[n] ? m_rf[n] : 5'd0);
            m_irq[n] = TRAP_ON && ((m_irq[n] && !c) || (m_rv[n] && (m_rf[n] & mask) != 0));
        end
        m_au_valid = g0 | g1;
        if (g0) begin
            q.push_back('{cyc + LAT + 2, 1'b0, fake_add(req0_a, req0_b, req0_op), req0_b[4:0]});
            m_ptr = 1;
        end
        if (g1) begin
            q.push_back('{cyc + LAT + 2, 1'b1, fake_add(req1_a, req1_b, req1_op), req1_b[4:0]});
            m_ptr = 0;
        end
        cyc++;
    endtask

    task automatic check_outputs();
        bit g0, g1;
        model_grant(g0, g1);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("au_valid", au_valid, m_au_valid);
        chk("rsp0_valid", rsp0_valid, m_rv[0]);
        chk("rsp1_valid", rsp1_valid, m_rv[1]);
        chk("rsp0_p", rsp0_p, m_rp[0]);
        chk("rsp1_p", rsp1_p, m_rp[1]);
        chk("rsp0_flags", rsp0_flags, m_rf[0]);
        chk("rsp1_flags", rsp1_flags, m_rf[1]);
        chk("sticky0", sticky0, m_st[0]);
        chk("sticky1", sticky1, m_st[1]);
        if (TRAP_ON) begin
            chk("irq0", irq0, m_irq[0]);
            chk("irq1", irq1, m_irq[1]);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        req0_valid = 0;
        req1_valid = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Load requester n with random operands whose low B bits are the flags.
    task automatic set_req(input bit n, input bit v, input logic [4:0] fl);
        logic [31:0] a, b;
        a = $urandom;
        b = {$urandom} & 32'hFFFF_FFE0 | {27'd0, fl};
        if (n == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = 1'($urandom_range(0, 1));
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0; clr0 = 0; clr1 = 0;
        rst_n = 0;
        #2;
        model_reset();
        chk("rst_au_valid", au_valid, 0);
        chk("rst_au_a", au_a, 0);
        chk("rst_au_b", au_b, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_p", rsp0_p, 0);
        chk("rst_rsp1_flags", rsp1_flags, 0);
        chk("rst_sticky0", sticky0, 0);
        chk("rst_sticky1", sticky1, 0);
        chk("rst_irq0", irq0, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        idle(2);

        // Single op 1.0 + 2.0
        req0_valid = 1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; req0_op = 0;
        tick();
        idle(LAT + 1);
        chk("single_rsp0_valid", rsp0_valid, 1);
        chk("single_rsp0_p", rsp0_p, 32'h4040_0000);
        chk("single_sticky0", sticky0, 0);
        idle(3);

        // Sticky accumulation on requester 1, then clear colliding with a response
        set_req(1, 1, 5'b00001); tick();
        set_req(1, 1, 5'b10000); tick();
        idle(LAT + 4);
        chk("sticky1_acc", sticky1, 5'b10001);
        set_req(1, 1, 5'b01000); tick();
        idle(LAT);
        clr1 = 1; tick(); clr1 = 0;
        tick();
        chk("sticky1_clr_new", sticky1, 5'b01000);
        idle(3);

        // Contention: both valid for 8 cycles, pointer starts at requester 0
        set_req(0, 1, 5'd0); set_req(1, 1, 5'd0);
        #1 chk("cont_first_grant0", req0_ready, 1);
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1, 5'd0); set_req(1, 1, 5'd0);
            tick();
        end
        idle(LAT + 4);

        // Back-to-back single requester
        for (int i = 0; i < 5; i++) begin
            set_req(0, 1, 5'd0);
            #1 chk("b2b_ready0", req0_ready, 1);
            tick();
        end
        idle(LAT + 4);

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1, 5'd3); set_req(1, 1, 5'd4); tick();
        end
        idle(1);
        do_reset();
        idle(LAT + 4);
        set_req(0, 1, 5'd0); set_req(1, 1, 5'd0);
        #1 chk("ptr_after_rst", req0_ready, 1);
        tick();
        idle(LAT + 4);

        if (TRAP_ON) begin
            set_req(0, 1, 5'b10001); tick();
            idle(LAT + 4);
            chk("trap_irq0_set", irq0, 1);
            for (int i = 0; i < 4; i++) begin
                set_req(0, 1, 5'd0); set_req(1, 1, 5'd0);
                #1 chk("trap_ready0_blocked", req0_ready, 0);
                tick();
            end
            clr0 = 1; tick(); clr0 = 0;
            set_req(0, 1, 5'd0); set_req(1, 1, 5'd0);
            #1 chk("trap_regrant0", req0_ready, 1);
            tick();
            idle(LAT + 4);
            clr0 = 1; clr1 = 1; tick(); clr0 = 0; clr1 = 0;
        end

        // Random traffic with one mid-run reset
        for (int i = 0; i < 400; i++) begin
            set_req(0, $urandom_range(0, 3) != 0, 5'($urandom));
            set_req(1, $urandom_range(0, 3) != 0, 5'($urandom));
            clr0 = ($urandom_range(0, 7) == 0);
            clr1 = ($urandom_range(0, 7) == 0);
            if (i == 200) do_reset();
            else tick();
        end
        clr0 = 0; clr1 = 0;
        idle(LAT + 4);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
